// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return (byte_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, synchronous clear,
// plus a fixed debug read port.
module dmem_array #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TEST_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] test_word
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TEST_IX = ADDR_W'(TEST_ADDR);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Clear has priority so a write coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata     = mem_r[raddr];
  assign test_word = mem_r[TEST_IX];

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data-memory responder: accepts a word load/store, waits WAIT_CYCLES,
// then completes with a one-cycle ReadyM strobe while stalling the pipeline.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int TEST_ADDR   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ReqM,
  input  logic              WeM,
  input  logic [31:0]       AddrM,
  input  logic [DATA_W-1:0] WDataM,
  output logic [DATA_W-1:0] RDataM,
  output logic              ReadyM,
  output logic              ErrM,
  output logic              StallMem,
  output logic [15:0]       test_value
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W+1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;

  logic              accept_s;
  logic [ADDR_W+1:0] eff_addr_s;
  logic              eff_we_s;
  logic [DATA_W-1:0] eff_wdata_s;
  logic              misalign_s;
  logic              ready_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic [DATA_W-1:0] test_word_s;
  logic              unused_bits_s;

  assign accept_s = (state_r == IDLE) && ReqM && !RST;

  // With zero wait states the request completes in its own cycle, so the live
  // inputs are used instead of the latched copies.
  assign eff_addr_s  = ZERO_WAIT ? AddrM[ADDR_W+1:0] : addr_r;
  assign eff_we_s    = ZERO_WAIT ? WeM : we_r;
  assign eff_wdata_s = ZERO_WAIT ? WDataM : wdata_r;
  assign misalign_s  = is_misaligned(eff_addr_s[1:0]);

  assign ready_s    = (ZERO_WAIT ? accept_s : (state_r == DONE)) && !RST;
  assign mem_we_s   = ready_s && eff_we_s && !misalign_s;
  assign ReadyM     = ready_s;
  assign ErrM       = ready_s && misalign_s;
  assign RDataM     = (ready_s && !eff_we_s && !misalign_s) ? mem_rdata_s : '0;
  assign StallMem   = ReqM && !ready_s && !RST;
  assign test_value = test_word_s[15:0];

  assign unused_bits_s = ^{AddrM[31:ADDR_W+2], test_word_s[DATA_W-1:16]};

  // State, counter and request latches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r  <= AddrM[ADDR_W+1:0];
        we_r    <= WeM;
        wdata_r <= WDataM;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (ReqM) begin
          cnt_s = WAIT_INIT;
          if (ZERO_WAIT) begin
            state_s = IDLE;
          end else if (WAIT_CYCLES == 1) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!ReqM) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_s == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  dmem_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TEST_ADDR(TEST_ADDR)
  ) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .we       (mem_we_s),
    .waddr    (eff_addr_s[ADDR_W+1:2]),
    .wdata    (eff_wdata_s),
    .raddr    (eff_addr_s[ADDR_W+1:2]),
    .rdata    (mem_rdata_s),
    .test_word(test_word_s)
  );

endmodule
